// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: captures ID branch + prediction, resolves next cycle, flushes/redirects on mispredict.
// One-cycle capture-to-resolve latency; a squashed or stalled ID branch is dropped. Optional counters: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            ID_branch_i,
  input  logic [XLEN-1:0] ID_pc_i,
  input  logic [XLEN-1:0] ID_imm_i,
  input  logic            predict_i,
  input  logic [XLEN-1:0] ALUResult_i,
  output logic            flush_o,
  output logic [1:0]      pcSel_o,
  output logic [XLEN-1:0] redirectPC_o,
  output logic            upd_valid_o,
  output logic            upd_taken_o,
  output logic [31:0]     branchCount_o,
  output logic [31:0]     mispredCount_o
);

  localparam logic [1:0] PCSEL_NORMAL = 2'd0;
  localparam logic [1:0] PCSEL_FALL   = 2'd1;
  localparam logic [1:0] PCSEL_TARGET = 2'd2;

  logic            rec_valid_q, rec_valid_d;
  logic            rec_pred_q, rec_pred_d;
  logic [XLEN-1:0] rec_target_q, rec_target_d;
  logic [XLEN-1:0] rec_fall_q, rec_fall_d;

  logic taken;
  logic mispred;
  logic capture;

  always_comb begin
    taken   = rec_valid_q && (ALUResult_i == '0);
    mispred = rec_valid_q && (rec_pred_q != (ALUResult_i == '0));
  end

  always_comb begin
    flush_o      = 1'b0;
    pcSel_o      = PCSEL_NORMAL;
    redirectPC_o = '0;
    upd_valid_o  = rec_valid_q;
    upd_taken_o  = taken;
    if (mispred) begin
      flush_o = 1'b1;
      if (taken) begin
        pcSel_o      = PCSEL_TARGET;
        redirectPC_o = rec_target_q;
      end else begin
        pcSel_o      = PCSEL_FALL;
        redirectPC_o = rec_fall_q;
      end
    end
  end

  // The younger ID branch is squashed by our own flush, so it must not enter the record.
  always_comb begin
    capture      = ID_branch_i && !stall_i && !flush_o;
    rec_valid_d  = capture;
    rec_pred_d   = rec_pred_q;
    rec_target_d = rec_target_q;
    rec_fall_d   = rec_fall_q;
    if (capture) begin
      rec_pred_d   = predict_i;
      rec_target_d = ID_pc_i + (ID_imm_i << 1);
      rec_fall_d   = ID_pc_i + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_valid_q  <= 1'b0;
      rec_pred_q   <= 1'b0;
      rec_target_q <= '0;
      rec_fall_q   <= '0;
    end else begin
      rec_valid_q  <= rec_valid_d;
      rec_pred_q   <= rec_pred_d;
      rec_target_q <= rec_target_d;
      rec_fall_q   <= rec_fall_d;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Saturating: a wrapped counter would silently corrupt long-run statistics.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_o && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (flush_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount_o  = branch_cnt_q;
  assign mispredCount_o = mispred_cnt_q;
`else
  assign branchCount_o  = '0;
  assign mispredCount_o = '0;
`endif

endmodule
